// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: single-cycle ops pass through the external ALU,
// while MULT/DIV/REMDER run a 32-step radix-2 iteration before the response is held for the consumer.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        alu_negative,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_overflow,
  output logic        out_carry,
  output logic        out_negative
);

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_SUB    = 6'h01;
  localparam logic [5:0] OP_AND    = 6'h02;
  localparam logic [5:0] OP_OR     = 6'h03;
  localparam logic [5:0] OP_XOR    = 6'h04;
  localparam logic [5:0] OP_MULT   = 6'h08;
  localparam logic [5:0] OP_DIV    = 6'h09;
  localparam logic [5:0] OP_REMDER = 6'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Shift-add step on {partial_high, multiplier_low}; after 32 steps it holds the full product.
  function automatic logic [63:0] mult_step(input logic [63:0] work, input logic [31:0] mcand);
    logic [32:0] sum;
    sum = {1'b0, work[63:32]} + {1'b0, (work[0] ? mcand : 32'd0)};
    return {sum, work[31:1]};
  endfunction

  // Restoring step on {remainder, dividend/quotient}; quotient bits shift in at the bottom.
  function automatic logic [63:0] div_step(input logic [63:0] work, input logic [31:0] divisor);
    logic [32:0] trial;
    logic [32:0] diff;
    trial = {work[63:32], work[31]};
    diff  = trial - {1'b0, divisor};
    if (!diff[32]) begin
      return {diff[31:0], work[30:0], 1'b1};
    end else begin
      return {trial[31:0], work[30:0], 1'b0};
    end
  endfunction

  state_t      state_r, state_s;
  logic [4:0]  count_r, count_s;
  logic [5:0]  op_r, op_s;
  logic [31:0] a_r, a_s, b_r, b_s;
  logic [63:0] work_r, work_s, step_s;
  logic        in_ready_r, in_ready_s;
  logic        out_valid_r, out_valid_s;
  logic [31:0] res_r, res_s;
  logic        zero_r, zero_s, ovf_r, ovf_s, carry_r, carry_s, neg_r, neg_s;

  // State and datapath registers; reset clears everything and reopens the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= 5'd0;
      op_r        <= 6'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      work_r      <= 64'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      res_r       <= 32'd0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      carry_r     <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      op_r        <= op_s;
      a_r         <= a_s;
      b_r         <= b_s;
      work_r      <= work_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      res_r       <= res_s;
      zero_r      <= zero_s;
      ovf_r       <= ovf_s;
      carry_r     <= carry_s;
      neg_r       <= neg_s;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    op_s        = op_r;
    a_s         = a_r;
    b_s         = b_r;
    work_s      = work_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    res_s       = res_r;
    zero_s      = zero_r;
    ovf_s       = ovf_r;
    carry_s     = carry_r;
    neg_s       = neg_r;
    if (op_r == OP_MULT) begin
      step_s = mult_step(work_r, a_r);
    end else begin
      step_s = div_step(work_r, b_r);
    end

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          op_s       = in_op;
          a_s        = in_a;
          b_s        = in_b;
          in_ready_s = 1'b0;
          count_s    = 5'd0;
          if (in_op == OP_MULT) begin
            work_s  = {32'd0, in_b};
            state_s = ITER;
          end else if (((in_op == OP_DIV) || (in_op == OP_REMDER)) && (in_b != 32'd0)) begin
            work_s  = {32'd0, in_a};
            state_s = ITER;
          end else begin
            work_s  = 64'd0;
            state_s = EXEC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        // DIV/REMDER only land here with a zero divisor.
        if (op_r == OP_DIV) begin
          res_s = 32'hFFFF_FFFF;
          ovf_s = 1'b0;
          carry_s = 1'b0;
        end else if (op_r == OP_REMDER) begin
          res_s = a_r;
          ovf_s = 1'b0;
          carry_s = 1'b0;
        end else begin
          res_s   = alu_result;
          ovf_s   = alu_overflow;
          carry_s = alu_carry;
        end
        if ((op_r == OP_DIV) || (op_r == OP_REMDER)) begin
          zero_s = (res_s == 32'd0);
          neg_s  = res_s[31];
        end else begin
          zero_s = alu_zero;
          neg_s  = alu_negative;
        end
        out_valid_s = 1'b1;
        state_s     = DONE;
      end
      ITER: begin
        work_s = step_s;
        if (count_r == 5'd31) begin
          case (op_r)
            OP_MULT:   res_s = step_s[31:0];
            OP_DIV:    res_s = step_s[31:0];
            OP_REMDER: res_s = step_s[63:32];
            default:   res_s = 32'd0;
          endcase
          ovf_s       = (op_r == OP_MULT) ? (step_s[63:32] != 32'd0) : 1'b0;
          carry_s     = 1'b0;
          zero_s      = (res_s == 32'd0);
          neg_s       = res_s[31];
          count_s     = 5'd0;
          out_valid_s = 1'b1;
          state_s     = DONE;
        end else begin
          count_s = count_r + 5'd1;
          state_s = ITER;
        end
      end
      DONE: begin
        // Reopening the input takes effect after this edge, so no accept coincides with retire.
        if (out_ready) begin
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s     = IDLE;
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  assign in_ready     = in_ready_r;
  assign alu_a        = a_r;
  assign alu_b        = b_r;
  assign alu_ctrl     = op_r;
  assign out_valid    = out_valid_r;
  assign out_result   = res_r;
  assign out_zero     = zero_r;
  assign out_overflow = ovf_r;
  assign out_carry    = carry_r;
  assign out_negative = neg_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: driver pushes hand-computed responses, monitor pops
// and compares whenever out_valid rises, and checks the response holds while it waits.
module tb_alu_op_sequencer;

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_SUB    = 6'h01;
  localparam logic [5:0] OP_AND    = 6'h02;
  localparam logic [5:0] OP_OR     = 6'h03;
  localparam logic [5:0] OP_XOR    = 6'h04;
  localparam logic [5:0] OP_MULT   = 6'h08;
  localparam logic [5:0] OP_DIV    = 6'h09;
  localparam logic [5:0] OP_REMDER = 6'h0A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = 6'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow, alu_carry, alu_negative;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_overflow, out_carry, out_negative;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry), .alu_negative(alu_negative),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_carry(out_carry),
    .out_negative(out_negative)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU stand-in; carry on SUB is the borrow.
  logic [32:0] wide;
  always_comb begin
    wide         = 33'd0;
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[31:0];
        alu_carry    = wide[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      OP_SUB: begin
        wide         = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result   = wide[31:0];
        alu_carry    = wide[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
  end

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;   // {zero, overflow, carry, negative}
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   active = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: pop on out_valid rise, then require the response to stay frozen.
  always @(negedge clk) begin
    if (rst) begin
      active <= 1'b0;
    end else if (out_valid) begin
      if (!active) begin
        if (sb.size() == 0) begin
          timeout("unexpected_response");
        end else begin
          cur = sb.pop_front();
          chk("latency_cycle", cyc, cur.due);
          chk("result", out_result, cur.res);
          chk("flags_zocn", {28'd0, out_zero, out_overflow, out_carry, out_negative}, {28'd0, cur.flags});
        end
        active <= 1'b1;
      end else begin
        chk("hold_result", out_result, cur.res);
        chk("hold_flags", {28'd0, out_zero, out_overflow, out_carry, out_negative}, {28'd0, cur.flags});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end else begin
      active <= 1'b0;
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, output int k);
    int n;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("accept_wait");
    @(posedge clk);
    #1;
    k = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [3:0] flags, input int lat, input int hold);
    int k;
    int n;
    exp_t e;
    issue(op, a, b, k);
    e.res = res; e.flags = flags; e.due = k + lat;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("response_wait");
    // Stray requests while a response is pending must be ignored.
    for (int i = 0; i < hold; i++) begin
      in_op = OP_ADD; in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_valid = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("retire_in_ready", {31'd0, in_ready}, 32'd1);
    chk("retire_out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_alu_ctrl", {26'd0, alu_ctrl}, 32'd0);

    send(OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 1, 0);
    send(OP_MULT,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1100, 32, 0);
    send(OP_MULT,   32'd7,         32'd6,         32'd42,        4'b0000, 32, 0);
    send(OP_MULT,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0100, 32, 0);
    send(OP_DIV,    32'd100,       32'd7,         32'd14,        4'b0000, 32, 0);
    send(OP_REMDER, 32'd100,       32'd7,         32'd2,         4'b0000, 32, 0);
    send(OP_DIV,    32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 4'b0001, 32, 0);
    send(OP_REMDER, 32'd3,         32'd10,        32'd3,         4'b0000, 32, 0);
    send(OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 4'b0001, 1, 0);
    send(OP_REMDER, 32'd5,         32'd0,         32'd5,         4'b0000, 1, 0);
    send(OP_XOR,    32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 4'b0001, 1, 5);
    send(6'h3F,     32'd1,         32'd1,         32'd0,         4'b1000, 1, 0);

    // Reset in the middle of a MULT: no response may ever appear.
    issue(OP_MULT, 32'd123, 32'd456, k);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset_alu_a", alu_a, 32'd0);
    send(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0011, 1, 0);

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
